// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_send among NUM_REQ byte streams.
// The owner keeps the transmitter until a byte flagged last; tx_data is held for the whole frame.
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int TMO_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_ready,
  output logic                   timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HOLD_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(HOLD_TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic               last_flag;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [7:0]         pick_byte;
  logic [7:0]         owner_byte;
  logic [IDX_W-1:0]   next_ptr;
  int                 idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[IDX_W'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(idx);
      end
    end
  end

  assign pick_byte  = req_data[{pick_idx, 3'b000} +: 8];
  assign owner_byte = req_data[{owner, 3'b000} +: 8];
  assign next_ptr   = (owner == IDX_TOP) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      tmo_cnt     <= '0;
      owner       <= '0;
      last_flag   <= 1'b0;
    end else begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found && tx_ready) begin
            owner     <= pick_idx;
            grant     <= onehot(pick_idx);
            tx_data   <= pick_byte;
            req_ready <= onehot(pick_idx);
            last_flag <= req_last[pick_idx];
            state     <= S_START;
          end else begin
            grant <= '0;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!tx_ready) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (last_flag) begin
              grant  <= '0;
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end else begin
              tmo_cnt <= '0;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Only the owner may continue; everyone else waits for release.
          if (req_valid[owner]) begin
            tx_data   <= owner_byte;
            last_flag <= req_last[owner];
            req_ready <= onehot(owner);
            tmo_cnt   <= '0;
            state     <= S_START;
          end else if (tmo_cnt >= TMO_LAST) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            rr_ptr      <= next_ptr;
            tmo_cnt     <= TMO_MAX;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
